regfile_wr_arbiter: RTL and testbench

Write-port arbiter for the 32x32 `RegisterFile`, which has a single write port (`RegWr`/`RW`/`BusW`). It shares that port between two requesters:
- the pipeline writeback stage (primary), which always has priority and no backpressure;
- a multi-cycle unit such as mult/div (secondary), which uses a valid/ready handshake and is buffered in a small queue.

The block also exports per-register pending bits so decode can stall on hazards, and raises a stall request if the queued result starves.

---
 rtl/regfile_wr_arbiter_if.sv | 24 ++
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: primary/secondary write requests and the register-file write port.
interface regfile_wr_arbiter_if;
    logic        P_Wr;
    logic [4:0]  P_RW;
    logic [31:0] P_W;
    logic        S_Valid;
    logic [4:0]  S_RW;
    logic [31:0] S_W;
    logic        S_Ready;
    logic        RegWr;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic [31:0] Pending;
    logic        Stall;
    logic        Err;
    modport master (
        output P_Wr, P_RW, P_W, S_Valid, S_RW, S_W,
        input  S_Ready, RegWr, RW, BusW, Pending, Stall, Err
    );
    modport slave (
        input  P_Wr, P_RW, P_W, S_Valid, S_RW, S_W,
        output S_Ready, RegWr, RW, BusW, Pending, Stall, Err
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between a priority
// writeback stage and a queued valid/ready secondary, with hazard/starvation flags.
module regfile_wr_arbiter #(
    parameter int DEPTH     = 2,
    parameter int AGE_LIMIT = 4
) (
    input logic                 Clk,
    input logic                 Rst,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    fifo_rw_q [DEPTH];
    logic [4:0]    fifo_rw_d [DEPTH];
    logic [31:0]   fifo_w_q  [DEPTH];
    logic [31:0]   fifo_w_d  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    age_q, age_d;
    logic          regwr_q, regwr_d, stall_q, stall_d, err_q, err_d;
    logic [4:0]    rw_q, rw_d;
    logic [31:0]   busw_q, busw_d, pending;
    logic          p_go, full, push, pop;

    always_comb begin
        p_go = bus.P_Wr && (bus.P_RW != 5'd0);
        full = count_q == CW'(DEPTH);
        push = bus.S_Valid && !full && (bus.S_RW != 5'd0);
        pop  = !p_go && (count_q != '0);
        pending = '0;
        off = '0;
        // an entry is live when its distance from the head is below the count
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) pending[fifo_rw_q[i]] = 1'b1;
        end
        fifo_rw_d = fifo_rw_q;
        fifo_w_d  = fifo_w_q;
        if (push) begin
            fifo_rw_d[wr_ptr_q] = bus.S_RW;
            fifo_w_d[wr_ptr_q]  = bus.S_W;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        regwr_d  = p_go || pop;
        rw_d     = p_go ? bus.P_RW : pop ? fifo_rw_q[rd_ptr_q] : rw_q;
        busw_d   = p_go ? bus.P_W : pop ? fifo_w_q[rd_ptr_q] : busw_q;
        age_d    = (pop || count_d == '0) ? 4'd0 : (age_q == 4'd15) ? age_q : age_q + 4'd1;
        stall_d  = age_q >= 4'(AGE_LIMIT);
        err_d    = err_q || (p_go && pending[bus.P_RW]);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rw_q[i] <= '0;
                fifo_w_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            regwr_q  <= 1'b0;
            rw_q     <= '0;
            busw_q   <= '0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fifo_rw_q <= fifo_rw_d;
            fifo_w_q  <= fifo_w_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            age_q     <= age_d;
            regwr_q   <= regwr_d;
            rw_q      <= rw_d;
            busw_q    <= busw_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

    assign bus.S_Ready = !full;
    assign bus.RegWr   = regwr_q;
    assign bus.RW      = rw_q;
    assign bus.BusW    = busw_q;
    assign bus.Pending = pending;
    assign bus.Stall   = stall_q;
    assign bus.Err     = err_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized soak compared against a register-file scoreboard.
module tb_regfile_wr_arbiter;
    localparam int DEPTH = 2;

    typedef struct {
        logic        p_wr;
        logic [4:0]  p_rw;
        logic [31:0] p_w;
        logic        s_v;
        logic [4:0]  s_rw;
        logic [31:0] s_w;
        logic        e_wr;
        logic [4:0]  e_rw;
        logic [31:0] e_w;
        logic [31:0] e_pend;
        logic        e_rdy;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t vt[$];
    logic [31:0] dut_rf [32];
    logic [31:0] model_rf [32];
    logic [36:0] mq[$];
    int ready_bad = 0;

    regfile_wr_arbiter_if bus();
    regfile_wr_arbiter #(.DEPTH(DEPTH), .AGE_LIMIT(4)) dut (.Clk(clk), .Rst(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ew, input logic [4:0] erw, input logic [31:0] ebw,
                           input logic [31:0] epd, input logic erdy, input logic est, input logic eer);
        chk({tag, " RegWr"}, 32'(bus.RegWr), 32'(ew));
        chk({tag, " RW"}, 32'(bus.RW), 32'(erw));
        chk({tag, " BusW"}, bus.BusW, ebw);
        chk({tag, " Pending"}, bus.Pending, epd);
        chk({tag, " S_Ready"}, 32'(bus.S_Ready), 32'(erdy));
        chk({tag, " Stall"}, 32'(bus.Stall), 32'(est));
        chk({tag, " Err"}, 32'(bus.Err), 32'(eer));
    endtask

    task automatic add(input logic pw, input logic [4:0] prw, input logic [31:0] pwd,
                       input logic sv, input logic [4:0] srw, input logic [31:0] swd,
                       input logic ew, input logic [4:0] erw, input logic [31:0] ebw,
                       input logic [31:0] epd, input logic erdy, input logic est, input logic eer);
        vec_t v;
        v = '{pw, prw, pwd, sv, srw, swd, ew, erw, ebw, epd, erdy, est, eer};
        vt.push_back(v);
    endtask

    task automatic drive(input logic pw, input logic [4:0] prw, input logic [31:0] pwd,
                         input logic sv, input logic [4:0] srw, input logic [31:0] swd);
        bus.P_Wr = pw;
        bus.P_RW = prw;
        bus.P_W = pwd;
        bus.S_Valid = sv;
        bus.S_RW = srw;
        bus.S_W = swd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic soak_cycle;
        logic rdy;
        logic [36:0] e;
        rdy = mq.size() < DEPTH;
        if (bus.S_Ready !== rdy) ready_bad++;
        if (bus.P_Wr && bus.P_RW != 5'd0) model_rf[bus.P_RW] = bus.P_W;
        else if (mq.size() > 0) begin
            e = mq.pop_front();
            model_rf[e[36:32]] = e[31:0];
        end
        if (bus.S_Valid && rdy && bus.S_RW != 5'd0) mq.push_back({bus.S_RW, bus.S_W});
        step();
        if (bus.RegWr) dut_rf[bus.RW] = bus.BusW;
    endtask

    initial begin
        //   p_wr  p_rw   p_w         s_v   s_rw   s_w         wr    rw     busw        pending       rdy   stall err
        add(1'b1, 5'd3, 32'h33,     1'b1, 5'd7,  32'h77,     1'b1, 5'd3,  32'h33,     32'h0000_0080, 1'b1, 1'b0, 1'b0);
        add(1'b1, 5'd3, 32'h34,     1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h34,     32'h0000_0080, 1'b1, 1'b0, 1'b0);
        add(1'b1, 5'd3, 32'h35,     1'b0, 5'd0,  32'h0,      1'b1, 5'd3,  32'h35,     32'h0000_0080, 1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd7,  32'h77,     32'h0,         1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd7,  32'h77,     32'h0,         1'b1, 1'b0, 1'b0);
        add(1'b1, 5'd1, 32'h11,     1'b1, 5'd8,  32'h88,     1'b1, 5'd1,  32'h11,     32'h0000_0100, 1'b1, 1'b0, 1'b0);
        add(1'b1, 5'd1, 32'h12,     1'b1, 5'd9,  32'h99,     1'b1, 5'd1,  32'h12,     32'h0000_0300, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5'd1, 32'h13,     1'b1, 5'd10, 32'hAA,     1'b1, 5'd1,  32'h13,     32'h0000_0300, 1'b0, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b1, 5'd10, 32'hAA,     1'b1, 5'd8,  32'h88,     32'h0000_0200, 1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b1, 5'd10, 32'hAA,     1'b1, 5'd9,  32'h99,     32'h0000_0400, 1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd10, 32'hAA,     32'h0,         1'b1, 1'b0, 1'b0);
        add(1'b1, 5'd0, 32'hBEEF,   1'b1, 5'd0,  32'hDEAD,   1'b0, 5'd10, 32'hAA,     32'h0,         1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b1, 5'd0,  32'hDEAD,   1'b0, 5'd10, 32'hAA,     32'h0,         1'b1, 1'b0, 1'b0);
        add(1'b0, 5'd0, 32'h0,      1'b1, 5'd12, 32'hC0,     1'b0, 5'd10, 32'hAA,     32'h0000_1000, 1'b1, 1'b0, 1'b0);
        add(1'b1, 5'd12, 32'hC1,    1'b0, 5'd0,  32'h0,      1'b1, 5'd12, 32'hC1,     32'h0000_1000, 1'b1, 1'b0, 1'b1);
        add(1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 5'd12, 32'hC0,     32'h0,         1'b1, 1'b0, 1'b1);
        add(1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b0, 5'd12, 32'hC0,     32'h0,         1'b1, 1'b0, 1'b1);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].p_wr, vt[i].p_rw, vt[i].p_w, vt[i].s_v, vt[i].s_rw, vt[i].s_w);
            step();
            chk_all($sformatf("vec%0d", i), vt[i].e_wr, vt[i].e_rw, vt[i].e_w, vt[i].e_pend,
                    vt[i].e_rdy, vt[i].e_stall, vt[i].e_err);
        end

        // asynchronous reset with two entries queued behind a busy primary
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'hA5A5_A5A5);
        step();
        drive(1'b1, 5'd2, 32'h23, 1'b1, 5'd6, 32'h1);
        step();
        drive(1'b1, 5'd2, 32'h24, 1'b0, 5'd0, 32'h0);
        chk("midq Pending", bus.Pending, 32'h0000_0060);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst%0d RegWr", k), 32'(bus.RegWr), 32'h0);
        end

        // starvation of a single queued entry under a continuous primary
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20);
        for (int k = 0; k < 6; k++) begin
            step();
            drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
            chk($sformatf("starve%0d Stall", k), 32'(bus.Stall), (k >= 4) ? 32'h1 : 32'h0);
        end
        chk("starve Pending", bus.Pending, 32'h0010_0000);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk_all("starve_issue", 1'b1, 5'd20, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        chk_all("starve_clear", 1'b0, 5'd20, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);

        // randomized soak against a queue-based scoreboard of the register file
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            dut_rf[r] = 32'h0;
            model_rf[r] = 32'h0;
        end
        for (int c = 0; c < 5000; c++) begin
            drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            soak_cycle();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (DEPTH + 2) soak_cycle();
        chk("soak S_Ready mismatches", 32'(ready_bad), 32'h0);
        for (int r = 0; r < 32; r++) chk($sformatf("soak r%0d", r), dut_rf[r], model_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
